tablero_ttt: RTL and testbench



---
 rtl/tablero_ttt.sv | 183 ++++++++++++++++++
 tb/tb_tablero_ttt.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tablero_ttt.sv
// Tic-tac-toe board store and referee: validates moves, writes cells, detects wins and a full board.
// Optional macro TTT_LINEA_GANADORA_EN adds the lineaGanadora output (cells of the completed line(s)).
module tablero_ttt #(
  parameter int NCELDAS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jugador1Juega,
  input  logic        jugador2Juega,
  input  logic [3:0]  posicion,
  input  logic        limpiar,
  output logic [17:0] tablero,
  output logic        movimientoIlegal,
  output logic        hecho,
  output logic        ocupado,
  output logic        gane,
  output logic        noEspacio,
`ifdef TTT_LINEA_GANADORA_EN
  output logic [8:0]  lineaGanadora,
`endif
  output logic [1:0]  ganador
);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    VALIDAR = 2'd1,
    EVALUAR = 2'd2,
    FIN     = 2'd3
  } estado_t;

  // Cell mask (bit i = cell i) of each of the eight lines.
  function automatic logic [8:0] mascara_linea(input logic [2:0] idx);
    logic [8:0] m;
    case (idx)
      3'd0:    m = 9'b000_000_111;
      3'd1:    m = 9'b000_111_000;
      3'd2:    m = 9'b111_000_000;
      3'd3:    m = 9'b001_001_001;
      3'd4:    m = 9'b010_010_010;
      3'd5:    m = 9'b100_100_100;
      3'd6:    m = 9'b100_010_001;
      3'd7:    m = 9'b001_010_100;
      default: m = 9'b000_000_000;
    endcase
    return m;
  endfunction

  function automatic logic [8:0] celdas_ganadoras(input logic [8:0] propias);
    logic [8:0] acc;
    logic [8:0] m;
    acc = 9'b0;
    for (int l = 0; l < 8; l++) begin
      m   = mascara_linea(3'(l));
      acc = acc | (((propias & m) == m) ? m : 9'b0);
    end
    return acc;
  endfunction

  estado_t     estado_r, estado_s;
  logic [17:0] tablero_r, tablero_s, escrito_s;
  logic [3:0]  pos_r, pos_s;
  logic [1:0]  jugador_r, jugador_s;
  logic        ilegal_r, ilegal_s;
  logic        hecho_r, hecho_s;
  logic        gane_r, gane_s;
  logic        no_espacio_r, no_espacio_s;
  logic [1:0]  ganador_r, ganador_s;
  logic [8:0]  linea_r, linea_s, linea_eval_s;
  logic [8:0]  propias_s;
  logic [1:0]  celda_s;
  logic        lleno_s;

  // Per-cell decode of the current board against the latched move.
  always_comb begin
    celda_s   = 2'b00;
    escrito_s = tablero_r;
    propias_s = 9'b0;
    lleno_s   = 1'b1;
    for (int i = 0; i < NCELDAS; i++) begin
      celda_s              = celda_s | ((pos_r == i[3:0]) ? tablero_r[2*i +: 2] : 2'b00);
      escrito_s[2*i +: 2]  = (pos_r == i[3:0]) ? jugador_r : tablero_r[2*i +: 2];
      propias_s[i]         = (tablero_r[2*i +: 2] == jugador_r);
      lleno_s              = lleno_s & (tablero_r[2*i +: 2] != 2'b00);
    end
    linea_eval_s = celdas_ganadoras(propias_s);
  end

  // Next-state and next-output logic.
  always_comb begin
    estado_s     = estado_r;
    tablero_s    = tablero_r;
    pos_s        = pos_r;
    jugador_s    = jugador_r;
    ilegal_s     = 1'b0;
    hecho_s      = 1'b0;
    gane_s       = gane_r;
    no_espacio_s = no_espacio_r;
    ganador_s    = ganador_r;
    linea_s      = linea_r;
    case (estado_r)
      ESPERA: begin
        if (jugador1Juega && jugador2Juega) begin
          ilegal_s = 1'b1;
        end else if (jugador1Juega) begin
          pos_s     = posicion;
          jugador_s = 2'b01;
          estado_s  = VALIDAR;
        end else if (jugador2Juega) begin
          pos_s     = posicion;
          jugador_s = 2'b10;
          estado_s  = VALIDAR;
        end else begin
          estado_s = ESPERA;
        end
      end
      VALIDAR: begin
        if ((pos_r > 4'd8) || (celda_s != 2'b00)) begin
          ilegal_s = 1'b1;
          estado_s = ESPERA;
        end else begin
          tablero_s = escrito_s;
          estado_s  = EVALUAR;
        end
      end
      EVALUAR: begin
        gane_s       = (linea_eval_s != 9'b0);
        ganador_s    = (linea_eval_s != 9'b0) ? jugador_r : 2'b00;
        no_espacio_s = lleno_s;
        linea_s      = linea_eval_s;
        hecho_s      = 1'b1;
        estado_s     = ((linea_eval_s != 9'b0) || lleno_s) ? FIN : ESPERA;
      end
      FIN: begin
        estado_s = FIN;
      end
      default: begin
        estado_s = ESPERA;
      end
    endcase
  end

  // State and output registers; limpiar clears exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst || limpiar) begin
      estado_r     <= ESPERA;
      tablero_r    <= 18'b0;
      pos_r        <= 4'b0;
      jugador_r    <= 2'b00;
      ilegal_r     <= 1'b0;
      hecho_r      <= 1'b0;
      gane_r       <= 1'b0;
      no_espacio_r <= 1'b0;
      ganador_r    <= 2'b00;
      linea_r      <= 9'b0;
    end else begin
      estado_r     <= estado_s;
      tablero_r    <= tablero_s;
      pos_r        <= pos_s;
      jugador_r    <= jugador_s;
      ilegal_r     <= ilegal_s;
      hecho_r      <= hecho_s;
      gane_r       <= gane_s;
      no_espacio_r <= no_espacio_s;
      ganador_r    <= ganador_s;
      linea_r      <= linea_s;
    end
  end

  assign tablero          = tablero_r;
  assign movimientoIlegal = ilegal_r;
  assign hecho            = hecho_r;
  assign gane             = gane_r;
  assign noEspacio        = no_espacio_r;
  assign ganador          = ganador_r;
  assign ocupado          = (estado_r == VALIDAR) || (estado_r == EVALUAR);
`ifdef TTT_LINEA_GANADORA_EN
  assign lineaGanadora    = linea_r;
`else
  logic unused_linea_s;
  assign unused_linea_s   = ^linea_r;
`endif

endmodule

// File: tb/tb_tablero_ttt.sv
// Self-checking bench for tablero_ttt: directed vector table, hand sequences, and random play
// checked against a board-level reference model. Honors TTT_LINEA_GANADORA_EN when defined.
module tb_tablero_ttt;

  logic        clk = 1'b0;
  logic        rst, jugador1Juega, jugador2Juega, limpiar;
  logic [3:0]  posicion;
  logic [17:0] tablero;
  logic        movimientoIlegal, hecho, ocupado, gane, noEspacio;
  logic [1:0]  ganador;
`ifdef TTT_LINEA_GANADORA_EN
  logic [8:0]  lineaGanadora;
`endif

  always #5 clk = ~clk;

  tablero_ttt dut (
    .clk(clk), .rst(rst),
    .jugador1Juega(jugador1Juega), .jugador2Juega(jugador2Juega),
    .posicion(posicion), .limpiar(limpiar),
    .tablero(tablero), .movimientoIlegal(movimientoIlegal), .hecho(hecho),
    .ocupado(ocupado), .gane(gane), .noEspacio(noEspacio),
`ifdef TTT_LINEA_GANADORA_EN
    .lineaGanadora(lineaGanadora),
`endif
    .ganador(ganador)
  );

  int errores = 0;
  int checks  = 0;

  // Reference model: board as player numbers, plus progress of the move in flight.
  int         brd [9];
  int         pendiente;   // cycles of work left on the accepted move (0 = none)
  bit         terminado;
  int         mpos, mjug;
  bit         e_il, e_hecho, e_gane, e_noesp;
  int         e_gan;
  logic [8:0] e_linea;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errores++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {7'd0, tablero, movimientoIlegal, hecho, ocupado, gane, noEspacio, ganador};
  endfunction

  function automatic logic [31:0] modelo_vec();
    logic [17:0] t;
    logic [1:0]  g;
    t = 18'd0;
    for (int i = 0; i < 9; i++) t = t | (18'(brd[i]) << (2 * i));
    g = 2'(e_gan);
    return {7'd0, t, e_il, e_hecho, (pendiente != 0), e_gane, e_noesp, g};
  endfunction

  task automatic modelo_limpio();
    for (int i = 0; i < 9; i++) brd[i] = 0;
    pendiente = 0; terminado = 1'b0; mpos = 0; mjug = 0;
    e_il = 1'b0; e_hecho = 1'b0; e_gane = 1'b0; e_noesp = 1'b0; e_gan = 0; e_linea = 9'd0;
  endtask

  task automatic paso_modelo(input bit a, input bit b, input int p, input bit lim, input bit r);
    logic [8:0] lin;
    bit         lleno;
    e_il = 1'b0; e_hecho = 1'b0;
    if (!r || lim) begin
      modelo_limpio();
    end else if (!terminado) begin
      if (pendiente == 0) begin
        if (a && b) e_il = 1'b1;
        else if (a || b) begin mpos = p; mjug = a ? 1 : 2; pendiente = 2; end
      end else if (pendiente == 2) begin
        if (mpos > 8 || brd[mpos] != 0) begin e_il = 1'b1; pendiente = 0; end
        else begin brd[mpos] = mjug; pendiente = 1; end
      end else begin
        lin = 9'd0;
        for (int k = 0; k < 3; k++) begin
          if (brd[3*k] == mjug && brd[3*k+1] == mjug && brd[3*k+2] == mjug) lin = lin | (9'b000000111 << (3*k));
          if (brd[k] == mjug && brd[k+3] == mjug && brd[k+6] == mjug) lin = lin | (9'b001001001 << k);
        end
        if (brd[0] == mjug && brd[4] == mjug && brd[8] == mjug) lin = lin | 9'b100010001;
        if (brd[2] == mjug && brd[4] == mjug && brd[6] == mjug) lin = lin | 9'b001010100;
        lleno = 1'b1;
        for (int i = 0; i < 9; i++) if (brd[i] == 0) lleno = 1'b0;
        e_linea = lin; e_gane = (lin != 9'd0); e_gan = e_gane ? mjug : 0; e_noesp = lleno;
        e_hecho = 1'b1; pendiente = 0;
        terminado = e_gane || lleno;
      end
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare just after it.
  task automatic ciclo(input bit a, input bit b, input logic [3:0] p, input bit lim, input bit r);
    jugador1Juega = a; jugador2Juega = b; posicion = p; limpiar = lim; rst = r;
    @(posedge clk);
    paso_modelo(a, b, int'(p), lim, r);
    #1;
    chk("ciclo", dut_vec(), modelo_vec());
`ifdef TTT_LINEA_GANADORA_EN
    chk("linea", {23'd0, lineaGanadora}, {23'd0, e_linea});
`endif
  endtask

  task automatic mover(input int jug, input logic [3:0] p);
    ciclo(jug == 1, jug == 2, p, 1'b0, 1'b1);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  typedef struct packed {
    logic        a, b;
    logic [3:0]  p;
    logic        lim, r;
    logic [17:0] tab;
    logic        il, he, oc, ga, ne;
    logic [1:0]  gn;
  } vec_t;

  vec_t tabla [12];

  initial begin
    jugador1Juega = 1'b0; jugador2Juega = 1'b0; posicion = 4'd0; limpiar = 1'b0; rst = 1'b0;
    modelo_limpio();
    tabla[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[1]  = '{1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 18'h00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    tabla[2]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    tabla[3]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[4]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[5]  = '{1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    tabla[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[8]  = '{1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    tabla[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[10] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tabla[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    #2;

    for (int v = 0; v < 12; v++) begin
      ciclo(tabla[v].a, tabla[v].b, tabla[v].p, tabla[v].lim, tabla[v].r);
      chk("tabla", dut_vec(), {7'd0, tabla[v].tab, tabla[v].il, tabla[v].he, tabla[v].oc,
                               tabla[v].ga, tabla[v].ne, tabla[v].gn});
    end

    // Player 1 wins on the top row; later requests are ignored.
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    mover(1, 4'd0); mover(2, 4'd3); mover(1, 4'd1); mover(2, 4'd4); mover(1, 4'd2);
    chk("gane", {31'd0, gane}, 32'd1);
    chk("ganador", {30'd0, ganador}, 32'd1);
    chk("hecho_gane", {31'd0, hecho}, 32'd1);
`ifdef TTT_LINEA_GANADORA_EN
    chk("linea_fila0", {23'd0, lineaGanadora}, 32'h7);
`endif
    ciclo(1'b1, 1'b0, 4'd8, 1'b0, 1'b1);
    chk("fin_ocupado", {31'd0, ocupado}, 32'd0);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("fin_tablero", {14'd0, tablero}, {14'd0, 18'b000000001010010101});

    // Limpiar during evaluation aborts the move; next move proceeds normally.
    ciclo(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    ciclo(1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    ciclo(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("limpiar_eval", dut_vec(), 32'd0);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("limpiar_sin_hecho", {31'd0, hecho}, 32'd0);
    mover(2, 4'd7);
    chk("tras_limpiar", {14'd0, tablero}, {14'd0, 18'h08000});

    // Draw, then reset from FIN.
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    mover(1, 4'd0); mover(2, 4'd1); mover(1, 4'd2); mover(2, 4'd4); mover(1, 4'd3);
    mover(2, 4'd5); mover(1, 4'd7); mover(2, 4'd6); mover(1, 4'd8);
    chk("empate_noEspacio", {31'd0, noEspacio}, 32'd1);
    chk("empate_gane", {31'd0, gane}, 32'd0);
    chk("empate_ganador", {30'd0, ganador}, 32'd0);
    ciclo(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("empate_ignora", {31'd0, ocupado}, 32'd0);
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst_en_fin", dut_vec(), 32'd0);
    mover(1, 4'd0);
    chk("tras_rst", {14'd0, tablero}, 32'd1);
    chk("tras_rst_hecho", {31'd0, hecho}, 32'd1);

    // Random play against the model.
    ciclo(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      ciclo($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 10)),
            $urandom_range(0, 59) == 0, $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
